bp_fe_fetch_queue: RTL and testbench

Front-end fetch response queue between the I-side memory stage and the backend. It tracks the PC of every fetch the PC generator issues into the memory stage and pairs each two-cycle-latency response with its PC. Instructions and fetch exceptions are buffered in a credit-protected FIFO toward the backend. Instruction-cache misses are returned to the PC generator as replay requests, and younger in-flight fetches are dropped.

---
 rtl/bp_fe_fetch_queue.sv | 123 ++++++++++++
 tb/tb_bp_fe_fetch_queue.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_fe_fetch_queue.sv
// Front-end fetch response queue: tracks in-flight fetch PCs, pairs each memory
// response with its PC, buffers results toward the backend and raises replays on icache misses.
module bp_fe_fetch_queue #(
  parameter int vaddr_width_p = 39,
  parameter int instr_width_p = 32,
  parameter int fifo_els_p    = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic [vaddr_width_p-1:0] fetch_pc_i,
  input  logic                     fetch_issue_i,
  output logic                     fetch_ready_o,
  input  logic                     poison_i,
  input  logic                     mem_resp_v_i,
  input  logic [instr_width_p-1:0] mem_resp_data_i,
  input  logic                     mem_resp_access_fault_i,
  input  logic                     mem_resp_page_fault_i,
  input  logic                     mem_resp_itlb_miss_i,
  input  logic                     mem_resp_icache_miss_i,
  output logic                     replay_v_o,
  output logic [vaddr_width_p-1:0] replay_pc_o,
  input  logic                     flush_i,
  output logic                     fe_v_o,
  output logic [vaddr_width_p-1:0] fe_pc_o,
  output logic [instr_width_p-1:0] fe_instr_o,
  output logic [1:0]               fe_exc_o,
  input  logic                     fe_ready_i
);

  localparam int ptr_w_lp = $clog2(fifo_els_p);
  localparam int cnt_w_lp = ptr_w_lp + 1;
  localparam logic [cnt_w_lp-1:0] els_lp = cnt_w_lp'(fifo_els_p);

  logic                     v_r_q, v_r_d, v_rr_q, v_rr_d;
  logic [vaddr_width_p-1:0] pc_r_q, pc_r_d, pc_rr_q, pc_rr_d;
  logic [ptr_w_lp-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [cnt_w_lp-1:0]      count_q, count_d;

  logic [vaddr_width_p-1:0] mem_pc_q    [fifo_els_p];
  logic [instr_width_p-1:0] mem_instr_q [fifo_els_p];
  logic [1:0]               mem_exc_q   [fifo_els_p];

  logic                     paired, is_exc, replay_v, kill, enq, deq;
  logic [1:0]               enq_exc;
  logic [instr_width_p-1:0] enq_instr;
  logic [cnt_w_lp-1:0]      free_slots, in_flight;

  always_comb begin
    paired   = mem_resp_v_i & v_rr_q;
    is_exc   = mem_resp_access_fault_i | mem_resp_page_fault_i | mem_resp_itlb_miss_i;
    replay_v = paired & ~is_exc & mem_resp_icache_miss_i & ~flush_i;
    kill     = flush_i | replay_v;
    enq      = paired & (is_exc | ~mem_resp_icache_miss_i) & ~flush_i;
    deq      = (count_q != '0) & fe_ready_i;

    enq_exc   = 2'd0;
    enq_instr = '0;
    if (mem_resp_access_fault_i)    enq_exc = 2'd3;
    else if (mem_resp_page_fault_i) enq_exc = 2'd2;
    else if (mem_resp_itlb_miss_i)  enq_exc = 2'd1;
    else                            enq_instr = mem_resp_data_i;

    v_r_d   = fetch_issue_i & ~kill;
    pc_r_d  = fetch_pc_i;
    v_rr_d  = v_r_q & ~poison_i & ~kill;
    pc_rr_d = pc_r_q;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq) wr_ptr_d = wr_ptr_q + 1'b1;
      if (deq) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + cnt_w_lp'(enq) - cnt_w_lp'(deq);
    end

    // Credit counts only registered state so every tracked fetch owns a slot.
    free_slots = els_lp - count_q;
    in_flight  = cnt_w_lp'(v_r_q) + cnt_w_lp'(v_rr_q);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      v_r_q    <= 1'b0;
      v_rr_q   <= 1'b0;
      pc_r_q   <= '0;
      pc_rr_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      v_r_q    <= v_r_d;
      v_rr_q   <= v_rr_d;
      pc_r_q   <= pc_r_d;
      pc_rr_q  <= pc_rr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) begin
      mem_pc_q[wr_ptr_q]    <= pc_rr_q;
      mem_instr_q[wr_ptr_q] <= enq_instr;
      mem_exc_q[wr_ptr_q]   <= enq_exc;
    end
  end

  assign fetch_ready_o = free_slots > in_flight;
  assign replay_v_o    = replay_v;
  assign replay_pc_o   = pc_rr_q;
  assign fe_v_o        = count_q != '0;
  // Storage is not reset, so head fields are forced to zero while empty.
  assign fe_pc_o       = fe_v_o ? mem_pc_q[rd_ptr_q]    : '0;
  assign fe_instr_o    = fe_v_o ? mem_instr_q[rd_ptr_q] : '0;
  assign fe_exc_o      = fe_v_o ? mem_exc_q[rd_ptr_q]   : 2'd0;

endmodule

// File: tb/tb_bp_fe_fetch_queue.sv
// Directed bench for bp_fe_fetch_queue: per-cycle vector table plus hand-written
// credit, flush and reset sequences.
module tb_bp_fe_fetch_queue;

  localparam int VA = 39;
  localparam int IW = 32;
  localparam int ELS = 8;

  logic          clk_i = 1'b0;
  logic          reset_n_i = 1'b0;
  logic [VA-1:0] fetch_pc_i = '0;
  logic          fetch_issue_i = 1'b0;
  logic          fetch_ready_o;
  logic          poison_i = 1'b0;
  logic          mem_resp_v_i = 1'b0;
  logic [IW-1:0] mem_resp_data_i = '0;
  logic          af_i = 1'b0, pf_i = 1'b0, itlb_i = 1'b0, ic_i = 1'b0;
  logic          replay_v_o;
  logic [VA-1:0] replay_pc_o;
  logic          flush_i = 1'b0;
  logic          fe_v_o;
  logic [VA-1:0] fe_pc_o;
  logic [IW-1:0] fe_instr_o;
  logic [1:0]    fe_exc_o;
  logic          fe_ready_i = 1'b1;

  int tests = 0;
  int fails = 0;

  bp_fe_fetch_queue #(.vaddr_width_p(VA), .instr_width_p(IW), .fifo_els_p(ELS)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .fetch_pc_i(fetch_pc_i), .fetch_issue_i(fetch_issue_i), .fetch_ready_o(fetch_ready_o),
    .poison_i(poison_i), .mem_resp_v_i(mem_resp_v_i), .mem_resp_data_i(mem_resp_data_i),
    .mem_resp_access_fault_i(af_i), .mem_resp_page_fault_i(pf_i),
    .mem_resp_itlb_miss_i(itlb_i), .mem_resp_icache_miss_i(ic_i),
    .replay_v_o(replay_v_o), .replay_pc_o(replay_pc_o), .flush_i(flush_i),
    .fe_v_o(fe_v_o), .fe_pc_o(fe_pc_o), .fe_instr_o(fe_instr_o), .fe_exc_o(fe_exc_o),
    .fe_ready_i(fe_ready_i)
  );

  always #5 clk_i = ~clk_i;

  // Enqueue into a full queue without a same-cycle dequeue is a design error.
  always @(posedge clk_i) begin
    if (reset_n_i && dut.enq && !dut.deq && dut.count_q == 4'(ELS)) begin
      fails++;
      $display("FAIL overflow: enqueue with count=%0d, required count < %0d", dut.count_q, ELS);
    end
  end

  typedef struct {
    logic          iss;
    logic [VA-1:0] pc;
    logic          poison;
    logic          rv;
    logic [IW-1:0] data;
    logic [3:0]    st;     // {access, page, itlb, icache}
    logic          flush;
    logic          rdy;
    logic          e_fr;
    logic          e_rep;
    logic [VA-1:0] e_rpc;
    logic          e_fev;
    logic [VA-1:0] e_pc;
    logic [IW-1:0] e_ins;
    logic [1:0]    e_exc;
  } vec_t;

  vec_t vecs[$];

  task automatic v(input logic iss, input logic [VA-1:0] pc, input logic poison,
                   input logic rv, input logic [IW-1:0] data, input logic [3:0] st,
                   input logic flush, input logic rdy, input logic e_fr, input logic e_rep,
                   input logic [VA-1:0] e_rpc, input logic e_fev, input logic [VA-1:0] e_pc,
                   input logic [IW-1:0] e_ins, input logic [1:0] e_exc);
    vec_t r;
    r.iss = iss; r.pc = pc; r.poison = poison; r.rv = rv; r.data = data; r.st = st;
    r.flush = flush; r.rdy = rdy; r.e_fr = e_fr; r.e_rep = e_rep; r.e_rpc = e_rpc;
    r.e_fev = e_fev; r.e_pc = e_pc; r.e_ins = e_ins; r.e_exc = e_exc;
    vecs.push_back(r);
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic idle_inputs();
    fetch_issue_i = 1'b0; fetch_pc_i = '0; poison_i = 1'b0; mem_resp_v_i = 1'b0;
    mem_resp_data_i = '0; {af_i, pf_i, itlb_i, ic_i} = 4'b0; flush_i = 1'b0;
  endtask

  localparam logic [VA-1:0] P = 39'h80000000;

  initial begin
    // stream: fe_v from cycle 3, in-order dequeue
    v(1, P,     0, 0, 32'h0,   4'b0000, 0, 1, 1, 0, 0,      0, 0,      0,        0);
    v(1, P+4,   0, 0, 32'h0,   4'b0000, 0, 1, 1, 0, 0,      0, 0,      0,        0);
    v(1, P+8,   0, 1, 32'h13,  4'b0000, 0, 1, 1, 0, 0,      0, 0,      0,        0);
    v(0, 0,     0, 1, 32'h93,  4'b0000, 0, 1, 1, 0, 0,      1, P,      32'h13,   0);
    v(0, 0,     0, 1, 32'h113, 4'b0000, 0, 1, 1, 0, 0,      1, P+4,    32'h93,   0);
    v(0, 0,     0, 0, 32'h0,   4'b0000, 0, 1, 1, 0, 0,      1, P+8,    32'h113,  0);
    v(0, 0,     0, 0, 32'h0,   4'b0000, 0, 1, 1, 0, 0,      0, 0,      0,        0);
    // poison kills 0x104, stray response ignored
    v(1, 'h100, 0, 0, 32'h0,   4'b0000, 0, 1, 1, 0, 0,      0, 0,      0,        0);
    v(1, 'h104, 0, 0, 32'h0,   4'b0000, 0, 1, 1, 0, 0,      0, 0,      0,        0);
    v(0, 0,     1, 1, 32'hAA,  4'b0000, 0, 1, 1, 0, 0,      0, 0,      0,        0);
    v(0, 0,     0, 1, 32'hBB,  4'b0000, 0, 1, 1, 0, 0,      1, 'h100,  32'hAA,   0);
    v(0, 0,     0, 0, 32'h0,   4'b0000, 0, 1, 1, 0, 0,      0, 0,      0,        0);
    // icache miss: replay, drop 0x204, untracked same-cycle issue of 0x208
    v(1, 'h200, 0, 0, 32'h0,   4'b0000, 0, 1, 1, 0, 0,      0, 0,      0,        0);
    v(1, 'h204, 0, 0, 32'h0,   4'b0000, 0, 1, 1, 0, 0,      0, 0,      0,        0);
    v(1, 'h208, 0, 1, 32'h55,  4'b0001, 0, 1, 1, 1, 'h200,  0, 0,      0,        0);
    v(0, 0,     0, 1, 32'h66,  4'b0000, 0, 1, 1, 0, 0,      0, 0,      0,        0);
    v(0, 0,     0, 1, 32'h77,  4'b0000, 0, 1, 1, 0, 0,      0, 0,      0,        0);
    v(0, 0,     0, 0, 32'h0,   4'b0000, 0, 1, 1, 0, 0,      0, 0,      0,        0);
    // exception priority: access > page > itlb > icache
    v(1, 'h300, 0, 0, 32'h0,   4'b0000, 0, 1, 1, 0, 0,      0, 0,      0,        0);
    v(0, 0,     0, 0, 32'h0,   4'b0000, 0, 1, 1, 0, 0,      0, 0,      0,        0);
    v(0, 0,     0, 1, 32'hDEAD,4'b1010, 0, 1, 1, 0, 0,      0, 0,      0,        0);
    v(0, 0,     0, 0, 32'h0,   4'b0000, 0, 1, 1, 0, 0,      1, 'h300,  0,        3);
    v(1, 'h400, 0, 0, 32'h0,   4'b0000, 0, 1, 1, 0, 0,      0, 0,      0,        0);
    v(0, 0,     0, 0, 32'h0,   4'b0000, 0, 1, 1, 0, 0,      0, 0,      0,        0);
    v(0, 0,     0, 1, 32'hBEEF,4'b0111, 0, 1, 1, 0, 0,      0, 0,      0,        0);
    v(0, 0,     0, 0, 32'h0,   4'b0000, 0, 1, 1, 0, 0,      1, 'h400,  0,        2);
    v(1, 'h500, 0, 0, 32'h0,   4'b0000, 0, 1, 1, 0, 0,      0, 0,      0,        0);
    v(0, 0,     0, 0, 32'h0,   4'b0000, 0, 1, 1, 0, 0,      0, 0,      0,        0);
    v(0, 0,     0, 1, 32'hCAFE,4'b0011, 0, 1, 1, 0, 0,      0, 0,      0,        0);
    v(0, 0,     0, 0, 32'h0,   4'b0000, 0, 1, 1, 0, 0,      1, 'h500,  0,        1);
    // flush beats a same-cycle enqueue and suppresses a replay
    v(1, 'h600, 0, 0, 32'h0,   4'b0000, 0, 1, 1, 0, 0,      0, 0,      0,        0);
    v(0, 0,     0, 0, 32'h0,   4'b0000, 0, 1, 1, 0, 0,      0, 0,      0,        0);
    v(0, 0,     0, 1, 32'h1234,4'b0000, 1, 1, 1, 0, 0,      0, 0,      0,        0);
    v(0, 0,     0, 0, 32'h0,   4'b0000, 0, 1, 1, 0, 0,      0, 0,      0,        0);
    v(1, 'h700, 0, 0, 32'h0,   4'b0000, 0, 1, 1, 0, 0,      0, 0,      0,        0);
    v(0, 0,     0, 0, 32'h0,   4'b0000, 0, 1, 1, 0, 0,      0, 0,      0,        0);
    v(0, 0,     0, 1, 32'h4321,4'b0001, 1, 1, 1, 0, 0,      0, 0,      0,        0);
    v(0, 0,     0, 0, 32'h0,   4'b0000, 0, 1, 1, 0, 0,      0, 0,      0,        0);

    // reset state
    idle_inputs();
    #1;
    chk("reset fe_v", fe_v_o, 0);
    chk("reset fetch_ready", fetch_ready_o, 1);
    chk("reset replay_v", replay_v_o, 0);
    chk("reset fe_pc", fe_pc_o, 0);
    chk("reset fe_instr", fe_instr_o, 0);
    chk("reset fe_exc", fe_exc_o, 0);
    repeat (2) @(negedge clk_i);
    reset_n_i = 1'b1;
    @(negedge clk_i);

    for (int i = 0; i < vecs.size(); i++) begin
      fetch_issue_i = vecs[i].iss; fetch_pc_i = vecs[i].pc; poison_i = vecs[i].poison;
      mem_resp_v_i = vecs[i].rv; mem_resp_data_i = vecs[i].data;
      {af_i, pf_i, itlb_i, ic_i} = vecs[i].st; flush_i = vecs[i].flush;
      fe_ready_i = vecs[i].rdy;
      #1;
      chk($sformatf("vec%0d fetch_ready", i), fetch_ready_o, vecs[i].e_fr);
      chk($sformatf("vec%0d replay_v", i), replay_v_o, vecs[i].e_rep);
      if (vecs[i].e_rep) chk($sformatf("vec%0d replay_pc", i), replay_pc_o, vecs[i].e_rpc);
      chk($sformatf("vec%0d fe_v", i), fe_v_o, vecs[i].e_fev);
      chk($sformatf("vec%0d fe_pc", i), fe_pc_o, vecs[i].e_pc);
      chk($sformatf("vec%0d fe_instr", i), fe_instr_o, vecs[i].e_ins);
      chk($sformatf("vec%0d fe_exc", i), fe_exc_o, vecs[i].e_exc);
      @(negedge clk_i);
    end

    // backpressure: issues at cycles 0..7, credit closes at cycle 8 (6 queued + 2 in flight)
    idle_inputs();
    fe_ready_i = 1'b0;
    for (int k = 0; k < 12; k++) begin
      fetch_issue_i = (k <= 7);
      fetch_pc_i = VA'('h1000 + 4 * k);
      mem_resp_v_i = (k >= 2 && k <= 9);
      mem_resp_data_i = IW'('h100 + k - 2);
      #1;
      chk($sformatf("bp cyc%0d fetch_ready", k), fetch_ready_o, (k <= 7));
      @(negedge clk_i);
    end
    idle_inputs();
    #1;
    chk("bp full fe_v", fe_v_o, 1);
    chk("bp full head pc", fe_pc_o, 'h1000);
    chk("bp full fetch_ready", fetch_ready_o, 0);
    fe_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("drain%0d fe_pc", i), fe_pc_o, 'h1000 + 4 * i);
      chk($sformatf("drain%0d fe_instr", i), fe_instr_o, 'h100 + i);
      @(negedge clk_i);
    end
    #1;
    chk("drain empty fe_v", fe_v_o, 0);
    chk("drain empty fetch_ready", fetch_ready_o, 1);
    @(negedge clk_i);

    // flush with credit-full queue: 6 queued + 2 in flight
    fe_ready_i = 1'b0;
    for (int k = 0; k < 9; k++) begin
      fetch_issue_i = (k <= 7);
      fetch_pc_i = VA'('h2000 + 4 * k);
      mem_resp_v_i = (k >= 2);
      mem_resp_data_i = IW'('h200 + k - 2);
      flush_i = (k == 8);
      #1;
      chk($sformatf("fl cyc%0d fetch_ready", k), fetch_ready_o, (k <= 7));
      if (k == 8) chk("fl before head pc", fe_pc_o, 'h2000);
      @(negedge clk_i);
    end
    idle_inputs();
    mem_resp_v_i = 1'b1;
    mem_resp_data_i = 32'h999;
    #1;
    chk("fl after fe_v", fe_v_o, 0);
    chk("fl after fetch_ready", fetch_ready_o, 1);
    @(negedge clk_i);
    mem_resp_v_i = 1'b0;
    #1;
    chk("fl late resp fe_v", fe_v_o, 0);
    @(negedge clk_i);

    // asynchronous reset mid-operation, then a fresh fetch
    fe_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      fetch_issue_i = (k == 0); fetch_pc_i = 'h3000;
      mem_resp_v_i = (k == 2); mem_resp_data_i = 32'h77;
      @(negedge clk_i);
    end
    idle_inputs();
    fetch_issue_i = 1'b1; fetch_pc_i = 'h3004;
    #1;
    chk("pre-reset fe_v", fe_v_o, 1);
    reset_n_i = 1'b0;
    #1;
    chk("async reset fe_v", fe_v_o, 0);
    chk("async reset fe_pc", fe_pc_o, 0);
    chk("async reset fetch_ready", fetch_ready_o, 1);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    idle_inputs();
    @(negedge clk_i);
    for (int k = 0; k < 4; k++) begin
      fetch_issue_i = (k == 0); fetch_pc_i = 'h3100;
      mem_resp_v_i = (k == 2); mem_resp_data_i = 32'h99;
      #1;
      if (k == 3) begin
        chk("post-reset fe_pc", fe_pc_o, 'h3100);
        chk("post-reset fe_instr", fe_instr_o, 32'h99);
      end else begin
        chk($sformatf("post-reset cyc%0d fe_v", k), fe_v_o, 0);
      end
      @(negedge clk_i);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
